// File: rtl/seq_rca_adder.sv
// seq_rca_adder: multi-cycle ripple-carry adder.
// WIDTH-bit operands are summed CHUNK bits per clock. A carry register links
// consecutive chunks, so the combinational carry chain is only CHUNK bits long.
// Handshake: start (accepted in IDLE or DONE), busy while computing, and a
// one-cycle done pulse when sum/cout hold a new result.
// Optional feature macro: RCA_SUB_EN adds the 'sub' port (A - B mode).
// When that macro is undefined, the design only adds and has no inverter.

module seq_rca_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
`ifdef RCA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Number of chunk cycles per operation.
  localparam int NCH   = WIDTH / CHUNK;
  // Counter width. It is at least one bit, so the NCH=1 case still has a counter.
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
  // Chunk slots are padded to a power of two.
  // This lets the counter index them without going out of range.
  localparam int NSLOT = 1 << CW;

  // Reject configurations that cannot be split into whole chunks.
  generate
    if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("seq_rca_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic             capture;      // accept start and load the operand registers
  logic             last_chunk;   // the counter points at the most significant chunk

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] psum_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic [WIDTH-1:0] b_capture;    // operand B as it is stored (inverted when subtracting)
  logic             cin_capture;  // initial carry as it is stored

  logic [CHUNK-1:0] a_slot [NSLOT];
  logic [CHUNK-1:0] b_slot [NSLOT];
  logic [CHUNK-1:0] a_sel;
  logic [CHUNK-1:0] b_sel;
  logic [CHUNK:0]   chunk_sum;    // CHUNK sum bits plus the carry out of the chunk
  logic [WIDTH-1:0] psum_merged;  // partial sum with the current chunk inserted

  assign last_chunk = (cnt_reg == CW'(NCH - 1));

  // Next-state and handshake decode for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        // A start request while running is ignored on purpose. It is not queued.
        if (last_chunk) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        // A start request in DONE goes straight back to RUN, so there is no idle bubble.
        if (start) begin
          capture    = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Operand conditioning at capture time.
  // In subtract mode, B is stored inverted and the initial carry is forced to 1.
  // The caller's cin is ignored in that mode.
  always_comb begin
    b_capture   = in2;
    cin_capture = cin;
`ifdef RCA_SUB_EN
    if (sub) begin
      b_capture   = ~in2;
      cin_capture = 1'b1;
    end
`endif
  end

  // Split the operand registers into chunk slots. Padding slots read as zero.
  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NCH) begin : g_used
        assign a_slot[gi] = a_reg[gi*CHUNK +: CHUNK];
        assign b_slot[gi] = b_reg[gi*CHUNK +: CHUNK];
      end else begin : g_pad
        assign a_slot[gi] = '0;
        assign b_slot[gi] = '0;
      end
    end
  endgenerate

  assign a_sel = a_slot[cnt_reg];
  assign b_sel = b_slot[cnt_reg];

  // The only carry chain in the design: one CHUNK-bit add plus the carry register.
  assign chunk_sum = {1'b0, a_sel} + {1'b0, b_sel} + {{CHUNK{1'b0}}, carry_reg};

  // Build the partial sum with the chunk being processed this cycle put in place.
  // On the final chunk, this vector is the complete result.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_merge
      assign psum_merged[gi*CHUNK +: CHUNK] =
        (cnt_reg == CW'(gi)) ? chunk_sum[CHUNK-1:0] : psum_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand capture, chunk counter and inter-chunk carry.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (capture) begin
      a_reg     <= in1;
      b_reg     <= b_capture;
      carry_reg <= cin_capture;
      cnt_reg   <= '0;
    end else if (state_reg == ST_RUN) begin
      carry_reg <= chunk_sum[CHUNK];
      cnt_reg   <= cnt_reg + 1'b1;
    end
  end

  // Partial-sum accumulation, one chunk per RUN cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      psum_reg <= '0;
    end else if (state_reg == ST_RUN) begin
      psum_reg <= psum_merged;
    end
  end

  // Result registers. They change only on the completion edge or on reset.
  // A reset during RUN therefore clears them, and no done pulse is produced.
  always_ff @(posedge clock) begin
    if (reset) begin
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else if ((state_reg == ST_RUN) && last_chunk) begin
      sum_reg  <= psum_merged;
      cout_reg <= chunk_sum[CHUNK];
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_seq_rca_adder.sv
// Directed bench for seq_rca_adder.
// It uses a 16/4 instance and a 4/1 instance that share one clock and one reset.
// Stimulus changes on the falling edge. Outputs are sampled on the falling edge.
// Subtract vectors run only when RCA_SUB_EN is defined.

module tb_seq_rca_adder;

  logic        clock;
  logic        reset;

  logic        start_16;
  logic [15:0] in1_16;
  logic [15:0] in2_16;
  logic        cin_16;
  logic        sub_16;
  logic        busy_16;
  logic        done_16;
  logic [15:0] sum_16;
  logic        cout_16;

  logic        start_4;
  logic [3:0]  in1_4;
  logic [3:0]  in2_4;
  logic        cin_4;
  logic        sub_4;
  logic        busy_4;
  logic        done_4;
  logic [3:0]  sum_4;
  logic        cout_4;

  int          n_checks;
  int          n_errors;

  seq_rca_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clock (clock),
    .reset (reset),
    .start (start_16),
    .in1   (in1_16),
    .in2   (in2_16),
    .cin   (cin_16),
`ifdef RCA_SUB_EN
    .sub   (sub_16),
`endif
    .busy  (busy_16),
    .done  (done_16),
    .sum   (sum_16),
    .cout  (cout_16)
  );

  seq_rca_adder #(.WIDTH(4), .CHUNK(1)) dut4 (
    .clock (clock),
    .reset (reset),
    .start (start_4),
    .in1   (in1_4),
    .in2   (in2_4),
    .cin   (cin_4),
`ifdef RCA_SUB_EN
    .sub   (sub_4),
`endif
    .busy  (busy_4),
    .done  (done_4),
    .sum   (sum_4),
    .cout  (cout_4)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation on the 16-bit instance.
  // It checks latency, busy duration, the result and that done lasts a single cycle.
  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic s,
                      input logic [15:0] exp_sum, input logic exp_cout);
    int n;
    int nb;
    bit seen;
    @(negedge clock);
    in1_16 = a; in2_16 = b; cin_16 = c; sub_16 = s; start_16 = 1'b1;
    @(negedge clock);
    start_16 = 1'b0;
    n = 1; nb = 0; seen = 1'b0;
    while (!seen && n <= 12) begin
      if (busy_16) nb++;
      if (done_16) seen = 1'b1;
      else begin
        @(negedge clock);
        n++;
      end
    end
    check_eq({tag, "_latency"}, n, 5);
    check_eq({tag, "_busy_cycles"}, nb, 4);
    check_eq({tag, "_sum"}, sum_16, exp_sum);
    check_eq({tag, "_cout"}, cout_16, exp_cout);
    $display("op16 %s: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d latency=%0d",
             tag, a, b, c, s, sum_16, cout_16, n);
    @(negedge clock);
    check_eq({tag, "_done_one_cycle"}, done_16, 1'b0);
  endtask

  // One operation on the 4-bit, 1-bit-chunk instance.
  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic c, input logic [3:0] exp_sum, input logic exp_cout);
    int n;
    bit seen;
    @(negedge clock);
    in1_4 = a; in2_4 = b; cin_4 = c; start_4 = 1'b1;
    @(negedge clock);
    start_4 = 1'b0;
    n = 1; seen = 1'b0;
    while (!seen && n <= 12) begin
      if (done_4) seen = 1'b1;
      else begin
        @(negedge clock);
        n++;
      end
    end
    check_eq({tag, "_latency"}, n, 5);
    check_eq({tag, "_sum"}, sum_4, exp_sum);
    check_eq({tag, "_cout"}, cout_4, exp_cout);
    $display("op4 %s: a=%b b=%b cin=%0d -> sum=%b cout=%0d latency=%0d",
             tag, a, b, c, sum_4, cout_4, n);
  endtask

  initial begin
    int n;
    int d1;
    int d2;
    int ndone;
    bit seen;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    start_16 = 1'b0; in1_16 = '0; in2_16 = '0; cin_16 = 1'b0; sub_16 = 1'b0;
    start_4  = 1'b0; in1_4  = '0; in2_4  = '0; cin_4  = 1'b0; sub_4  = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_busy", busy_16, 1'b0);
    check_eq("rst_done", done_16, 1'b0);
    check_eq("rst_sum", sum_16, 16'h0000);
    check_eq("rst_cout", cout_16, 1'b0);
    reset = 1'b0;

    // Basic adds, including a carry that ripples across every chunk boundary.
    op16("t1_5555_aaaa", 16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1);
    op16("t2_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    op16("t2_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);

    // Single-bit chunks.
    op4("t3_0101_1010", 4'b0101, 4'b1010, 1'b1, 4'b0000, 1'b1);
    op4("t3_1011_1101", 4'b1011, 4'b1101, 1'b0, 4'b1000, 1'b1);

    // A start request during RUN must not disturb the operation in flight.
    @(negedge clock);
    in1_16 = 16'h0F0F; in2_16 = 16'h0101; cin_16 = 1'b0; start_16 = 1'b1;
    @(negedge clock);
    start_16 = 1'b0;
    @(negedge clock);
    in1_16 = 16'hFFFF; in2_16 = 16'hFFFF; cin_16 = 1'b1; start_16 = 1'b1;
    @(negedge clock);
    start_16 = 1'b0;
    n = 3; seen = 1'b0;
    while (!seen && n <= 12) begin
      if (done_16) seen = 1'b1;
      else begin
        @(negedge clock);
        n++;
      end
    end
    check_eq("t4_ignore_latency", n, 5);
    check_eq("t4_ignore_sum", sum_16, 16'h1010);
    check_eq("t4_ignore_cout", cout_16, 1'b0);
    $display("t4 restart-in-run: sum=%h cout=%0d latency=%0d", sum_16, cout_16, n);

    // Start held high: the second operation is captured straight from DONE.
    @(negedge clock);
    in1_16 = 16'h8000; in2_16 = 16'h8000; cin_16 = 1'b0; start_16 = 1'b1;
    n = 0; d1 = 0; d2 = 0;
    while (d2 == 0 && n <= 25) begin
      @(negedge clock);
      n++;
      if (done_16) begin
        if (d1 == 0) begin
          d1 = n;
          check_eq("t4_b2b_first_sum", sum_16, 16'h0000);
          check_eq("t4_b2b_first_cout", cout_16, 1'b1);
          $display("t4 back-to-back #1: sum=%h cout=%0d at cycle %0d", sum_16, cout_16, n);
          in1_16 = 16'h00FF; in2_16 = 16'h0001; cin_16 = 1'b1;
        end else begin
          d2 = n;
          check_eq("t4_b2b_second_sum", sum_16, 16'h0101);
          check_eq("t4_b2b_second_cout", cout_16, 1'b0);
          $display("t4 back-to-back #2: sum=%h cout=%0d at cycle %0d", sum_16, cout_16, n);
          start_16 = 1'b0;
        end
      end
    end
    start_16 = 1'b0;
    check_eq("t4_b2b_first_latency", d1, 5);
    check_eq("t4_b2b_period", d2 - d1, 5);

    // Reset two cycles into RUN aborts the operation and clears the result.
    @(negedge clock);
    @(negedge clock);
    in1_16 = 16'h1111; in2_16 = 16'h2222; cin_16 = 1'b0; start_16 = 1'b1;
    @(negedge clock);
    start_16 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("t5_rst_busy", busy_16, 1'b0);
    check_eq("t5_rst_done", done_16, 1'b0);
    check_eq("t5_rst_sum", sum_16, 16'h0000);
    check_eq("t5_rst_cout", cout_16, 1'b0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done_16) ndone++;
    end
    check_eq("t5_no_done_after_abort", ndone, 0);
    $display("t5 reset mid-run: sum=%h cout=%0d later_done=%0d", sum_16, cout_16, ndone);

`ifdef RCA_SUB_EN
    // Subtract mode. The caller's cin is ignored, so it is deliberately set to 0 here.
    op16("t6_0005_sub_0007", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    op16("t6_0007_sub_0005", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
